// File: rtl/jt6295_pkg.sv
// Shared widths for the JT6295 ROM fetch path: 18-bit byte addresses into
// 16-bit external memory words, filled four bytes (one cache line) at a time.
package jt6295_pkg;

    localparam int ROM_AW     = 18;
    localparam int MEM_DW     = 16;
    localparam int LINE_BYTES = 4;
    localparam int MEM_AW     = ROM_AW - 1;
    localparam int LINE_AW    = ROM_AW - $clog2(LINE_BYTES);

    typedef logic [ROM_AW-1:0] rom_addr_t;
    typedef logic [MEM_DW-1:0] mem_word_t;

    function automatic logic [7:0] pick_byte(input mem_word_t word0, input mem_word_t word1,
                                             input logic [1:0] sel);
        mem_word_t word;
        word = sel[1] ? word1 : word0;
        return sel[0] ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/jt6295_romfetch_mem.sv
// Direct-mapped line storage: valid bits (reset), tags and two data words per
// line (no reset). Combinational read port, synchronous write port.
module jt6295_romfetch_mem
    import jt6295_pkg::*;
#(
    parameter  int LINES = 8,
    localparam int IDX_W = $clog2(LINES),
    localparam int TAG_W = LINE_AW - IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output mem_word_t        rd_word0,
    output mem_word_t        rd_word1,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_data_en,
    input  logic             wr_word_sel,
    input  mem_word_t        wr_data,
    input  logic             wr_tag_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             set_valid
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q   [LINES];
    mem_word_t        word0_q [LINES];
    mem_word_t        word1_q [LINES];

    // flush wins over a same-edge valid set so a bank swap can never be missed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_data_en && !wr_word_sel) word0_q[wr_idx] <= wr_data;
        if (wr_data_en &&  wr_word_sel) word1_q[wr_idx] <= wr_data;
        if (wr_tag_en)                  tag_q[wr_idx]   <= wr_tag;
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_word0 = word0_q[rd_idx];
    assign rd_word1 = word1_q[rd_idx];

endmodule

// File: rtl/jt6295_romfetch.sv
// Small direct-mapped read cache between the ADPCM core ROM port and a
// 16-bit request/ack/data-valid memory. One line fill outstanding at a time.
//   state | meaning
//   IDLE  | lookup every cycle; hit updates served data, miss starts a fill
//   REQ   | mem_req held with the line's first word address until mem_ack
//   BEAT0 | waiting for word 0 of the line
//   BEAT1 | waiting for word 1; then tag written, line marked valid
module jt6295_romfetch
    import jt6295_pkg::*;
#(
    parameter int LINES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [ROM_AW-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              rom_ok,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_dv,
    input  logic [MEM_DW-1:0] mem_data
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = LINE_AW - IDX_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] BEAT0 = 2'd2;
    localparam logic [1:0] BEAT1 = 2'd3;

    logic [1:0]         state_q;
    logic [LINE_AW-1:0] line_q;
    logic               fill_flushed_q;
    logic               served_valid_q;
    rom_addr_t          served_addr_q;

    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    mem_word_t          rd_word0;
    mem_word_t          rd_word1;
    logic               hit;
    logic               wr_data_en;
    logic               last_beat;
    logic               set_valid;

    assign hit        = rd_valid && (rd_tag == rom_addr[ROM_AW-1:IDX_W+2]);
    assign wr_data_en = mem_dv && ((state_q == BEAT0) || (state_q == BEAT1));
    assign last_beat  = mem_dv && (state_q == BEAT1);
    // a flush seen at any point of the fill means the data may be from the old bank
    assign set_valid  = last_beat && !fill_flushed_q && !flush;
    assign rom_ok     = served_valid_q && (served_addr_q == rom_addr);

    jt6295_romfetch_mem #(.LINES(LINES)) u_mem (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .rd_idx      (rom_addr[IDX_W+1:2]),
        .rd_valid    (rd_valid),
        .rd_tag      (rd_tag),
        .rd_word0    (rd_word0),
        .rd_word1    (rd_word1),
        .wr_idx      (line_q[IDX_W-1:0]),
        .wr_data_en  (wr_data_en),
        .wr_word_sel (state_q == BEAT1),
        .wr_data     (mem_data),
        .wr_tag_en   (last_beat),
        .wr_tag      (line_q[LINE_AW-1:IDX_W]),
        .set_valid   (set_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            line_q         <= '0;
            fill_flushed_q <= 1'b0;
            served_valid_q <= 1'b0;
            served_addr_q  <= '0;
            rom_data       <= 8'd0;
            mem_req        <= 1'b0;
            mem_addr       <= '0;
        end else begin
            if (flush) served_valid_q <= 1'b0;
            if (flush && (state_q != IDLE)) fill_flushed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        if (!flush) begin
                            rom_data       <= pick_byte(rd_word0, rd_word1, rom_addr[1:0]);
                            served_addr_q  <= rom_addr;
                            served_valid_q <= 1'b1;
                        end
                    end else begin
                        line_q         <= rom_addr[ROM_AW-1:2];
                        mem_addr       <= {rom_addr[ROM_AW-1:2], 1'b0};
                        mem_req        <= 1'b1;
                        fill_flushed_q <= 1'b0;
                        state_q        <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state_q <= BEAT0;
                    end
                end
                BEAT0: begin
                    if (mem_dv) state_q <= BEAT1;
                end
                BEAT1: begin
                    if (mem_dv) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jt6295_romfetch.sv
// Directed bench for jt6295_romfetch with a behavioural memory responder
// whose ack delay and inter-beat gap are adjustable per scenario.
module tb_jt6295_romfetch;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [17:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        mem_ack;
    logic        mem_dv;
    logic [15:0] mem_data;

    int checks = 0;
    int errors = 0;

    // driven by the test sequence
    bit resp_en   = 1'b1;
    int ack_delay = 0;
    int dv_gap    = 0;
    int abort_cnt = 0;
    int stray_cnt = 0;

    // owned by the responder
    int          phase        = 0;
    int          cnt          = 0;
    logic [16:0] req_addr     = '0;
    int          fills        = 0;
    int          unstable_cnt = 0;
    int          abort_seen   = 0;
    int          stray_done   = 0;

    jt6295_romfetch #(.LINES(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_dv   (mem_dv),
        .mem_data (mem_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] word_of(input logic [16:0] wa);
        if (wa == 17'h8) return 16'hBBAA;
        if (wa == 17'h9) return 16'hDDCC;
        return {~wa[7:0], wa[7:0]};
    endfunction

    function automatic logic [7:0] exp_byte(input logic [17:0] a);
        logic [15:0] w;
        w = word_of(a[17:1]);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    // responder updates at the falling edge, so the DUT samples stable values
    initial begin
        mem_ack  = 1'b0;
        mem_dv   = 1'b0;
        mem_data = 16'h0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            mem_dv  = 1'b0;
            if (abort_cnt != abort_seen) begin
                abort_seen = abort_cnt;
                phase      = 0;
            end else if (stray_cnt != stray_done) begin
                stray_done = stray_cnt;
                mem_dv     = 1'b1;
                mem_data   = 16'hEEEE;
            end else begin
                if (phase == 1 && mem_req && mem_addr !== req_addr) unstable_cnt++;
                if (phase == 0 && mem_req === 1'b1 && resp_en) begin
                    phase    = 1;
                    cnt      = ack_delay;
                    req_addr = mem_addr;
                end
                if (phase == 1) begin
                    if (cnt == 0) begin
                        mem_ack = 1'b1;
                        fills++;
                        phase = 2;
                    end else cnt--;
                end else if (phase == 2) begin
                    if (cnt == 0) begin
                        mem_dv   = 1'b1;
                        mem_data = word_of(req_addr);
                        phase    = 3;
                        cnt      = dv_gap;
                    end else cnt--;
                end else if (phase == 3) begin
                    if (cnt == 0) begin
                        mem_dv   = 1'b1;
                        mem_data = word_of(req_addr + 17'd1);
                        phase    = 0;
                    end else cnt--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ok(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rom_ok === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst_n    = 1'b0;
        flush    = 1'b0;
        rom_addr = 18'h0;
        repeat (3) tick();
        checks++; if (rom_ok !== 1'b0)     begin errors++; $display("FAIL rst_rom_ok got %h want 0", rom_ok); end
        checks++; if (rom_data !== 8'h00)  begin errors++; $display("FAIL rst_rom_data got %h want 00", rom_data); end
        checks++; if (mem_req !== 1'b0)    begin errors++; $display("FAIL rst_mem_req got %h want 0", mem_req); end
        checks++; if (mem_addr !== 17'h0)  begin errors++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
        rst_n = 1'b1;
        wait_ok(40, ok);
        checks++; if (!ok || rom_data !== 8'h00) begin errors++; $display("FAIL boot_fill got ok=%0d data=%h want ok=1 data=00", ok, rom_data); end
    endtask

    task automatic test_first_fill();
        int f0;
        f0 = fills;
        rom_addr = 18'h00010;
        repeat (4) tick();
        checks++; if (rom_ok !== 1'b0) begin errors++; $display("FAIL ff_early_ok got %h want 0", rom_ok); end
        tick();
        checks++; if (rom_ok !== 1'b1)      begin errors++; $display("FAIL ff_ok got %h want 1", rom_ok); end
        checks++; if (rom_data !== 8'hAA)   begin errors++; $display("FAIL ff_data got %h want aa", rom_data); end
        checks++; if (fills != f0 + 1)      begin errors++; $display("FAIL ff_fills got %0d want %0d", fills - f0, 1); end
        checks++; if (req_addr !== 17'h8)   begin errors++; $display("FAIL ff_mem_addr got %h want 00008", req_addr); end
    endtask

    task automatic test_hits();
        logic [17:0] ha [3];
        logic [7:0]  hd [3];
        int f0;
        ha = '{18'h11, 18'h12, 18'h13};
        hd = '{8'hBB, 8'hCC, 8'hDD};
        f0 = fills;
        for (int i = 0; i < 3; i++) begin
            rom_addr = ha[i];
            #1;
            checks++; if (rom_ok !== 1'b0) begin errors++; $display("FAIL hit_change_ok[%0d] got %h want 0", i, rom_ok); end
            tick();
            checks++; if (rom_ok !== 1'b1 || rom_data !== hd[i]) begin errors++; $display("FAIL hit_data[%0d] got ok=%h data=%h want ok=1 data=%h", i, rom_ok, rom_data, hd[i]); end
        end
        checks++; if (fills != f0) begin errors++; $display("FAIL hit_no_fill got %0d fills want 0", fills - f0); end
    endtask

    task automatic test_flush_conflict();
        logic [17:0] seq [3];
        int f0;
        bit ok;
        seq = '{18'h10, 18'h30, 18'h10};
        f0 = fills;
        rom_addr = 18'h10;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (rom_ok !== 1'b0) begin errors++; $display("FAIL flush_hit_ok got %h want 0", rom_ok); end
        for (int i = 0; i < 3; i++) begin
            rom_addr = seq[i];
            wait_ok(40, ok);
            checks++; if (!ok || rom_data !== exp_byte(seq[i])) begin errors++; $display("FAIL conflict_data[%0d] got ok=%0d data=%h want ok=1 data=%h", i, ok, rom_data, exp_byte(seq[i])); end
        end
        checks++; if (fills != f0 + 3) begin errors++; $display("FAIL conflict_fills got %0d want 3", fills - f0); end
    endtask

    task automatic test_flush_fill();
        int f0;
        bit ok;
        f0 = fills;
        rom_addr = 18'h30;
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_ok(60, ok);
        checks++; if (!ok || fills != f0 + 2) begin errors++; $display("FAIL flush_fill_refetch got ok=%0d fills=%0d want ok=1 fills=2", ok, fills - f0); end
        checks++; if (rom_data !== 8'h18) begin errors++; $display("FAIL flush_fill_data got %h want 18", rom_data); end
    endtask

    task automatic test_slow_mem();
        int f0;
        int u0;
        bit ok;
        ack_delay = 7;
        dv_gap    = 3;
        f0 = fills;
        u0 = unstable_cnt;
        rom_addr = 18'h01235;
        wait_ok(80, ok);
        checks++; if (!ok || rom_data !== 8'hE5)    begin errors++; $display("FAIL slow_data got ok=%0d data=%h want ok=1 data=e5", ok, rom_data); end
        checks++; if (req_addr !== 17'h0091A)       begin errors++; $display("FAIL slow_mem_addr got %h want 0091a", req_addr); end
        checks++; if (unstable_cnt != u0)           begin errors++; $display("FAIL slow_addr_stable got %0d changes want 0", unstable_cnt - u0); end
        checks++; if (fills != f0 + 1)              begin errors++; $display("FAIL slow_fills got %0d want 1", fills - f0); end
        ack_delay = 0;
        dv_gap    = 0;
    endtask

    task automatic test_reset_fill();
        int f0;
        bit ok;
        bit seen;
        dv_gap = 5;
        rom_addr = 18'h02202;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_dv === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rf_first_beat got none want dv"); end
        rst_n = 1'b0;
        abort_cnt++;
        tick();
        checks++; if (mem_req !== 1'b0 || rom_ok !== 1'b0 || mem_addr !== 17'h0) begin errors++; $display("FAIL rf_reset_state got req=%h ok=%h addr=%h want 0 0 0", mem_req, rom_ok, mem_addr); end
        resp_en = 1'b0;
        rst_n   = 1'b1;
        f0 = fills;
        repeat (2) tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 17'h01100) begin errors++; $display("FAIL rf_new_req got req=%h addr=%h want 1 01100", mem_req, mem_addr); end
        stray_cnt++;
        repeat (2) tick();
        checks++; if (rom_ok !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL rf_stray_ignored got ok=%h req=%h want 0 1", rom_ok, mem_req); end
        resp_en = 1'b1;
        dv_gap  = 0;
        wait_ok(40, ok);
        checks++; if (!ok || rom_data !== 8'h01) begin errors++; $display("FAIL rf_data got ok=%0d data=%h want ok=1 data=01", ok, rom_data); end
        checks++; if (fills != f0 + 1) begin errors++; $display("FAIL rf_fills got %0d want 1", fills - f0); end
    endtask

    initial begin
        test_reset();
        test_first_fill();
        test_hits();
        test_flush_conflict();
        test_flush_fill();
        test_slow_mem();
        test_reset_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jt6295_romfetch.md
JT6295_ROMFETCH -- requirements
Module: jt6295_romfetch

Interface
REQ-001 The block SHALL have parameter LINES, default 8, giving the number of direct-mapped cache lines (power of two, 2..64).
REQ-002 The block SHALL have a single clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 flush  input  1  single-cycle pulse that invalidates all lines (ROM bank swap).
REQ-006 rom_addr  input  18  byte address from the ADPCM core's ROM port.
REQ-007 rom_data  output  8  byte returned for rom_addr.
REQ-008 rom_ok  output  1  high only when rom_data belongs to the current rom_addr.
REQ-009 mem_req  output  1  fill request to external memory; held high until mem_ack.
REQ-010 mem_addr  output  17  16-bit word address of the first word of the line; stable while mem_req is high.
REQ-011 mem_ack  input  1  one-cycle acceptance of mem_req.
REQ-012 mem_dv  input  1  one-cycle data-valid strobe; exactly two strobes follow each mem_ack, possibly with gaps.
REQ-013 mem_data  input  16  word qualified by mem_dv; even byte in [7:0].

Function
REQ-014 A line SHALL be 4 bytes (2 words); index = rom_addr[log2(LINES)+1:2]; tag = the remaining upper bits; word select = rom_addr[1]; byte select = rom_addr[0].
REQ-015 FSM states SHALL be IDLE, REQ, BEAT0 and BEAT1; reset state IDLE.
REQ-016 In IDLE, a lookup SHALL occur every cycle; on a hit, rom_data and the served-address register SHALL update on the next edge (1-cycle latency).
REQ-017 rom_ok SHALL be computed combinationally as served_valid AND (served_addr == rom_addr), so stale data is never flagged ok after an address change.
REQ-018 A miss in IDLE SHALL capture the line address and move to REQ, asserting mem_req and mem_addr from the next cycle.
REQ-019 REQ SHALL advance to BEAT0 on mem_ack.
REQ-020 BEAT0 SHALL write word 0 on mem_dv and advance to BEAT1.
REQ-021 BEAT1 SHALL write word 1 on mem_dv, then write the tag, set valid, and return to IDLE.
REQ-022 A zero-wait memory (ack in the first REQ cycle, dv in the next two cycles) SHALL give rom_ok 5 cycles after the miss cycle.
REQ-023 If rom_addr changes during a fill, the fill SHALL still complete and write the line; the new address SHALL be looked up on return to IDLE.
REQ-024 flush SHALL clear all valid bits and served_valid in the same edge.
REQ-025 A flush during REQ/BEAT0/BEAT1 SHALL let the fill finish but leave that line invalid.
REQ-026 A flush coincident with a hit SHALL suppress the served-data update.
REQ-027 Data SHALL update only on mem_dv.
REQ-028 mem_ack or mem_dv arriving outside the expected state SHALL be ignored.
REQ-029 Only one fill SHALL be outstanding at a time; no prefetch.

Reset
REQ-030 On rst_n low: state IDLE, mem_req 0, mem_addr 0, rom_data 0, served_valid 0 (rom_ok 0), and all line valid bits 0.
REQ-031 Data and tag storage SHALL need no reset.
REQ-032 Reset during a fill SHALL abandon the fill; any later mem_dv SHALL be ignored.

Structure
REQ-033 The shared package jt6295_pkg SHALL hold the ROM address width (18), memory word width (16) and line size (4 bytes).
REQ-034 Tag/valid/data storage SHALL be one sub-module, jt6295_romfetch_mem, providing a combinational read and a synchronous write.

Verification
REQ-035 Reset, then rom_addr=0x00010 with zero-wait memory returning 0xBBAA and 0xDDCC: mem_addr=0x00008 once, rom_data=0xAA, rom_ok=1 at cycle +5.
REQ-036 After REQ-035, step rom_addr through 0x11, 0x12, 0x13: no mem_req, data 0xBB, 0xCC, 0xDD, each with 1-cycle latency; rom_ok low in each change cycle.
REQ-037 Access 0x00010, then 0x00030 (same index for LINES=8, different tag), then 0x00010: three fills in total.
REQ-038 Assert flush in BEAT0, then re-access the same address: a second fill is issued and rom_ok stays 0 until it completes.
REQ-039 With mem_ack delayed 7 cycles and a 3-cycle gap between dv strobes: mem_addr is stable throughout, and the correct byte is returned.
REQ-040 Assert rst_n low in BEAT1, release, then access the same address: a new fill occurs, and a stray mem_dv after reset causes no write.
